// File: rtl/edge_capture.sv
// Multi-channel edge detector: per-channel synchronizer, configurable edge/level
// event detection, sticky flags and saturating event counters with a registered readout.
module edge_capture #(
  parameter  int WIDTH       = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 8,
  localparam int SEL_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clr,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] flag,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] event_s;
  logic [CNT_W-1:0] counter_r [WIDTH];
  logic [CNT_W-1:0] cnt_next_s;

  assign q = sync_r[SYNC_STAGES-1];

  // Synchronizer chain, previous-level history and registered event pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
      prev_r <= '0;
      p      <= '0;
    end else begin
      sync_r[0] <= a;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
      prev_r <= q;
      p      <= event_s;
    end
  end

  // Event condition selected by the shared detect mode.
  always_comb begin
    event_s = '0;
    case (mode)
      2'b00:   event_s = q & ~prev_r;
      2'b01:   event_s = ~q & prev_r;
      2'b10:   event_s = q ^ prev_r;
      2'b11:   event_s = q;
      default: event_s = '0;
    endcase
  end

  // Sticky flags and saturating counters; an event wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      flag <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        counter_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (event_s[i]) begin
          flag[i] <= 1'b1;
          if (clr[i]) begin
            counter_r[i] <= CNT_ONE;
          end else if (counter_r[i] != CNT_MAX) begin
            counter_r[i] <= counter_r[i] + CNT_ONE;
          end else begin
            counter_r[i] <= counter_r[i];
          end
        end else if (clr[i]) begin
          flag[i]      <= 1'b0;
          counter_r[i] <= '0;
        end else begin
          flag[i]      <= flag[i];
          counter_r[i] <= counter_r[i];
        end
      end
    end
  end

  // Readout mux; an out-of-range select matches no channel and reads zero.
  always_comb begin
    cnt_next_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next_s = cnt_next_s | ((cnt_sel == SEL_W'(i)) ? counter_r[i] : '0);
    end
  end

  // Registered counter readout.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next_s;
    end
  end

endmodule

// File: tb/tb_edge_capture.sv
// Self-checking bench for edge_capture: directed scenarios plus randomized stimulus
// against a history-based reference model, on a default and a narrow/slow instance.
module tb_edge_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mode;
  logic [15:0] a_v   [2];
  logic [15:0] clr_v [2];
  logic [3:0]  sel_v [2];

  logic [3:0] q_a, p_a, flag_a;
  logic [7:0] cnt_a;
  logic [4:0] q_b, p_b, flag_b;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  edge_capture dut_a (
    .clock(clk), .reset_n(reset_n), .a(a_v[0][3:0]), .mode(mode),
    .clr(clr_v[0][3:0]), .cnt_sel(sel_v[0][1:0]),
    .q(q_a), .p(p_a), .flag(flag_a), .cnt(cnt_a)
  );

  edge_capture #(.WIDTH(5), .SYNC_STAGES(3), .CNT_W(2)) dut_b (
    .clock(clk), .reset_n(reset_n), .a(a_v[1][4:0]), .mode(mode),
    .clr(clr_v[1][4:0]), .cnt_sel(sel_v[1][2:0]),
    .q(q_b), .p(p_b), .flag(flag_b), .cnt(cnt_b)
  );

  // Reference model: q is the input sampled SS edges ago, events follow the mode rules.
  function automatic int w_of(input int d);  return (d == 0) ? 4 : 5;   endfunction
  function automatic int ss_of(input int d); return (d == 0) ? 2 : 3;   endfunction
  function automatic int max_of(input int d); return (d == 0) ? 255 : 3; endfunction

  logic [15:0] hist_m [2][4];
  logic [15:0] q_m [2], prev_m [2], p_m [2], flag_m [2];
  int          cnt_m [2][16];
  int          cout_m [2];
  logic [15:0] ev_m, mask_m;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mask_m = 16'((32'd1 << w_of(d)) - 32'd1);
      if (!reset_n) begin
        for (int s = 0; s < 4; s++) hist_m[d][s] = 16'h0;
        q_m[d] = 16'h0; prev_m[d] = 16'h0; p_m[d] = 16'h0; flag_m[d] = 16'h0;
        cout_m[d] = 0;
        for (int i = 0; i < 16; i++) cnt_m[d][i] = 0;
      end else begin
        case (mode)
          2'd0:    ev_m = q_m[d] & ~prev_m[d];
          2'd1:    ev_m = ~q_m[d] & prev_m[d];
          2'd2:    ev_m = q_m[d] ^ prev_m[d];
          default: ev_m = q_m[d];
        endcase
        ev_m = ev_m & mask_m;
        cout_m[d] = (int'(sel_v[d]) < w_of(d)) ? cnt_m[d][sel_v[d]] : 0;
        for (int i = 0; i < w_of(d); i++) begin
          if (ev_m[i]) begin
            flag_m[d][i] = 1'b1;
            if (clr_v[d][i]) cnt_m[d][i] = 1;
            else if (cnt_m[d][i] < max_of(d)) cnt_m[d][i] = cnt_m[d][i] + 1;
          end else if (clr_v[d][i]) begin
            flag_m[d][i] = 1'b0;
            cnt_m[d][i]  = 0;
          end
        end
        p_m[d]    = ev_m;
        prev_m[d] = q_m[d];
        for (int s = 3; s > 0; s--) hist_m[d][s] = hist_m[d][s-1];
        hist_m[d][0] = a_v[d] & mask_m;
        q_m[d] = hist_m[d][ss_of(d)-1];
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 8;
    if (q_a !== 4'h0)    begin n_fail++; $display("FAIL reset_q_a got %h expected 0", q_a); end
    if (p_a !== 4'h0)    begin n_fail++; $display("FAIL reset_p_a got %h expected 0", p_a); end
    if (flag_a !== 4'h0) begin n_fail++; $display("FAIL reset_flag_a got %h expected 0", flag_a); end
    if (cnt_a !== 8'h0)  begin n_fail++; $display("FAIL reset_cnt_a got %h expected 0", cnt_a); end
    if (q_b !== 5'h0)    begin n_fail++; $display("FAIL reset_q_b got %h expected 0", q_b); end
    if (p_b !== 5'h0)    begin n_fail++; $display("FAIL reset_p_b got %h expected 0", p_b); end
    if (flag_b !== 5'h0) begin n_fail++; $display("FAIL reset_flag_b got %h expected 0", flag_b); end
    if (cnt_b !== 2'h0)  begin n_fail++; $display("FAIL reset_cnt_b got %h expected 0", cnt_b); end
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [4:0] qa_t = 5'b11110, pa_t = 5'b00100, qb_t = 5'b11100, pb_t = 5'b01000;
    repeat (3) @(negedge clk);
    a_v[0][0] = 1'b1;
    a_v[1][0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks += 4;
      if (q_a[0] !== qa_t[c]) begin n_fail++; $display("FAIL lat_q_a c=%0d got %b expected %b", c, q_a[0], qa_t[c]); end
      if (p_a[0] !== pa_t[c]) begin n_fail++; $display("FAIL lat_p_a c=%0d got %b expected %b", c, p_a[0], pa_t[c]); end
      if (q_b[0] !== qb_t[c]) begin n_fail++; $display("FAIL lat_q_b c=%0d got %b expected %b", c, q_b[0], qb_t[c]); end
      if (p_b[0] !== pb_t[c]) begin n_fail++; $display("FAIL lat_p_b c=%0d got %b expected %b", c, p_b[0], pb_t[c]); end
      if (c == 2) begin
        n_checks++;
        if (flag_a[0] !== 1'b1) begin n_fail++; $display("FAIL lat_flag_a got %b expected 1", flag_a[0]); end
      end
      if (c == 3) begin
        n_checks++;
        if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL lat_cnt_a got %0d expected 1", cnt_a); end
      end
      if (c == 4) begin
        n_checks++;
        if (cnt_b !== 2'd1) begin n_fail++; $display("FAIL lat_cnt_b got %0d expected 1", cnt_b); end
      end
    end
  endtask

  task automatic test_both_edges();
    int pulses = 0, stray = 0;
    @(negedge clk);
    mode = 2'b10;
    clr_v[0] = 16'h000f;
    @(negedge clk);
    clr_v[0] = 16'h0;
    for (int c = 0; c < 24; c++) begin
      if ((c % 2 == 0) && (c < 12)) a_v[0][1] = ~a_v[0][1];
      @(negedge clk);
      if (p_a[1]) pulses++;
      if ((p_a & 4'b1101) != 4'b0000) stray++;
    end
    sel_v[0] = 4'd1;
    @(negedge clk);
    n_checks += 4;
    if (pulses !== 6) begin n_fail++; $display("FAIL both_pulses got %0d expected 6", pulses); end
    if (stray !== 0)  begin n_fail++; $display("FAIL both_other_channels got %0d expected 0", stray); end
    if (cnt_a !== 8'd6) begin n_fail++; $display("FAIL both_cnt got %0d expected 6", cnt_a); end
    if (flag_a !== 4'b0010) begin n_fail++; $display("FAIL both_flags got %b expected 0010", flag_a); end
  endtask

  task automatic test_level();
    int high_a = 0, run = 0, run_max = 0, high_b = 0;
    @(negedge clk);
    mode = 2'b11;
    for (int c = 0; c < 15; c++) begin
      if (c == 0) begin a_v[0][2] = 1'b1; a_v[1][2] = 1'b1; end
      if (c == 5) begin a_v[0][2] = 1'b0; a_v[1][2] = 1'b0; end
      @(negedge clk);
      if (p_a[2]) begin high_a++; run++; if (run > run_max) run_max = run; end
      else run = 0;
      if (p_b[2]) high_b++;
    end
    sel_v[0] = 4'd2;
    sel_v[1] = 4'd2;
    @(negedge clk);
    n_checks += 5;
    if (high_a !== 5)  begin n_fail++; $display("FAIL level_high_cycles got %0d expected 5", high_a); end
    if (run_max !== 5) begin n_fail++; $display("FAIL level_run got %0d expected 5", run_max); end
    if (high_b !== 5)  begin n_fail++; $display("FAIL level_high_b got %0d expected 5", high_b); end
    if (cnt_a !== 8'd5) begin n_fail++; $display("FAIL level_cnt got %0d expected 5", cnt_a); end
    if (cnt_b !== 2'd3) begin n_fail++; $display("FAIL level_saturate got %0d expected 3", cnt_b); end
  endtask

  task automatic test_clear();
    @(negedge clk);
    mode = 2'b00;
    sel_v[0] = 4'd0;
    clr_v[0][0] = 1'b1;
    @(negedge clk);
    clr_v[0][0] = 1'b0;
    n_checks++;
    if (flag_a[0] !== 1'b0) begin n_fail++; $display("FAIL clr_flag got %b expected 0", flag_a[0]); end
    @(negedge clk);
    n_checks++;
    if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL clr_cnt got %0d expected 0", cnt_a); end
    a_v[0][0] = 1'b0; repeat (4) @(negedge clk);
    a_v[0][0] = 1'b1; repeat (5) @(negedge clk);
    a_v[0][0] = 1'b0; repeat (4) @(negedge clk);
    a_v[0][0] = 1'b1;
    repeat (2) @(negedge clk);
    clr_v[0][0] = 1'b1;
    @(negedge clk);
    clr_v[0][0] = 1'b0;
    n_checks += 2;
    if (p_a[0] !== 1'b1)    begin n_fail++; $display("FAIL clr_evt_p got %b expected 1", p_a[0]); end
    if (flag_a[0] !== 1'b1) begin n_fail++; $display("FAIL clr_evt_flag got %b expected 1", flag_a[0]); end
    @(negedge clk);
    n_checks++;
    if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL clr_evt_cnt got %0d expected 1", cnt_a); end
  endtask

  task automatic test_reset_midflight();
    int pulses = 0;
    @(negedge clk);
    a_v[0][3] = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_checks += 4;
    if (q_a !== 4'h0)    begin n_fail++; $display("FAIL mid_q got %h expected 0", q_a); end
    if (p_a !== 4'h0)    begin n_fail++; $display("FAIL mid_p got %h expected 0", p_a); end
    if (flag_a !== 4'h0) begin n_fail++; $display("FAIL mid_flag got %h expected 0", flag_a); end
    if (cnt_a !== 8'h0)  begin n_fail++; $display("FAIL mid_cnt got %h expected 0", cnt_a); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (p_a[3]) pulses++;
    end
    n_checks += 2;
    if (pulses !== 1)       begin n_fail++; $display("FAIL mid_rise_pulses got %0d expected 1", pulses); end
    if (flag_a[3] !== 1'b1) begin n_fail++; $display("FAIL mid_rise_flag got %b expected 1", flag_a[3]); end
  endtask

  task automatic test_sel_range();
    sel_v[1] = 4'd5;
    @(negedge clk);
    n_checks++;
    if (cnt_b !== 2'd0) begin n_fail++; $display("FAIL sel5_cnt got %0d expected 0", cnt_b); end
    sel_v[1] = 4'd0;
    @(negedge clk);
    n_checks++;
    if (cnt_b !== 2'd1) begin n_fail++; $display("FAIL sel0_cnt got %0d expected 1", cnt_b); end
    sel_v[1] = 4'd7;
    @(negedge clk);
    n_checks++;
    if (cnt_b !== 2'd0) begin n_fail++; $display("FAIL sel7_cnt got %0d expected 0", cnt_b); end
  endtask

  task automatic test_random();
    logic [15:0] gq, gp, gf;
    int gc;
    reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        gq = (d == 0) ? {12'h0, q_a}    : {11'h0, q_b};
        gp = (d == 0) ? {12'h0, p_a}    : {11'h0, p_b};
        gf = (d == 0) ? {12'h0, flag_a} : {11'h0, flag_b};
        gc = (d == 0) ? int'(cnt_a)     : int'(cnt_b);
        n_checks += 4;
        if (gq !== q_m[d])    begin n_fail++; $display("FAIL rnd_q d=%0d c=%0d got %h expected %h", d, c, gq, q_m[d]); end
        if (gp !== p_m[d])    begin n_fail++; $display("FAIL rnd_p d=%0d c=%0d got %h expected %h", d, c, gp, p_m[d]); end
        if (gf !== flag_m[d]) begin n_fail++; $display("FAIL rnd_flag d=%0d c=%0d got %h expected %h", d, c, gf, flag_m[d]); end
        if (gc !== cout_m[d]) begin n_fail++; $display("FAIL rnd_cnt d=%0d c=%0d got %0d expected %0d", d, c, gc, cout_m[d]); end
      end
      if ($urandom_range(0, 3) == 0) a_v[0] = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a_v[1] = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      clr_v[0] = 16'($urandom & $urandom & $urandom) & 16'h000f;
      clr_v[1] = 16'($urandom & $urandom & $urandom) & 16'h001f;
      sel_v[0] = 4'($urandom_range(0, 3));
      sel_v[1] = 4'($urandom_range(0, 7));
      reset_n = ($urandom_range(0, 63) != 0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    mode     = 2'b00;
    a_v[0]   = 16'h0; a_v[1]   = 16'h0;
    clr_v[0] = 16'h0; clr_v[1] = 16'h0;
    sel_v[0] = 4'd0;  sel_v[1] = 4'd0;
    test_reset();
    test_latency();
    test_both_edges();
    test_level();
    test_clear();
    test_reset_midflight();
    test_sel_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
